// File: rtl/module_status_monitor_if.sv
// Handshake and read-port bundle for module_status_monitor.
// master drives the HLS handshakes and read requests; slave is the monitor side.
interface module_status_monitor_if #(
    parameter int unsigned NUM_CH = 13,
    parameter int unsigned CNT_W  = 32
);
    localparam int unsigned CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic [NUM_CH-1:0] ap_start;
    logic [NUM_CH-1:0] ap_ready;
    logic [NUM_CH-1:0] ap_done;
    logic [NUM_CH-1:0] ap_continue;
    logic              rd_en;
    logic [CH_W-1:0]   rd_ch;
    logic [2:0]        rd_sel;
    logic              rd_valid;
    logic [CNT_W-1:0]  rd_data;

    modport master (
        output ap_start, ap_ready, ap_done, ap_continue,
        output rd_en, rd_ch, rd_sel,
        input  rd_valid, rd_data
    );

    modport slave (
        input  ap_start, ap_ready, ap_done, ap_continue,
        input  rd_en, rd_ch, rd_sel,
        output rd_valid, rd_data
    );
endinterface

// File: rtl/module_status_monitor.sv
// Per-channel HLS handshake monitor with saturating performance counters and a registered read port.
// Define MODULE_STATUS_MONITOR_MAXLAT_EN to build the per-channel max-latency registers.
module module_status_monitor #(
    parameter int unsigned NUM_CH = 13,
    parameter int unsigned CNT_W  = 32
) (
    input  logic                       clock,
    input  logic                       reset,
    module_status_monitor_if.slave     mon,
    input  logic                       finish,
    input  logic                       clear,
    output logic                       frozen,
    output logic [NUM_CH-1:0]          overflow
);
    localparam int unsigned CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        BUSY      = 2'd1,
        DONE_HOLD = 2'd2
    } state_t;

    typedef logic [CNT_W-1:0] cnt_t;

    state_t state_q [NUM_CH];
    state_t state_d [NUM_CH];
    cnt_t   lat_q   [NUM_CH];
    cnt_t   lat_d   [NUM_CH];
    cnt_t   txn_q   [NUM_CH];
    cnt_t   txn_d   [NUM_CH];
    cnt_t   last_q  [NUM_CH];
    cnt_t   last_d  [NUM_CH];
    cnt_t   busy_q  [NUM_CH];
    cnt_t   busy_d  [NUM_CH];
    cnt_t   stall_q [NUM_CH];
    cnt_t   stall_d [NUM_CH];
    cnt_t   rdy_q   [NUM_CH];
    cnt_t   rdy_d   [NUM_CH];
`ifdef MODULE_STATUS_MONITOR_MAXLAT_EN
    cnt_t   max_q   [NUM_CH];
    cnt_t   max_d   [NUM_CH];
`endif
    logic [NUM_CH-1:0] ovf_d;
    logic              frozen_d;
    logic              hold;
    cnt_t              rd_val;

    function automatic cnt_t inc(input cnt_t v);
        return (v == '1) ? v : v + cnt_t'(1);
    endfunction

    // lat_cnt doubles as the recorded latency while a transaction waits in DONE_HOLD.
    always_comb begin
        logic cmpl;
        cnt_t rec;
        hold     = frozen | finish;
        frozen_d = hold;
        ovf_d    = overflow;
        cmpl     = 1'b0;
        rec      = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            state_d[i] = state_q[i];
            lat_d[i]   = lat_q[i];
            txn_d[i]   = txn_q[i];
            last_d[i]  = last_q[i];
            busy_d[i]  = busy_q[i];
            stall_d[i] = stall_q[i];
            rdy_d[i]   = rdy_q[i];
`ifdef MODULE_STATUS_MONITOR_MAXLAT_EN
            max_d[i]   = max_q[i];
`endif
            cmpl = 1'b0;
            rec  = lat_q[i];
            if (!hold) begin
                if (mon.ap_ready[i]) begin
                    rdy_d[i] = inc(rdy_q[i]);
                    if (rdy_q[i] == '1) ovf_d[i] = 1'b1;
                end
                unique case (state_q[i])
                    IDLE: begin
                        if (mon.ap_start[i]) begin
                            busy_d[i] = inc(busy_q[i]);
                            if (busy_q[i] == '1) ovf_d[i] = 1'b1;
                            rec      = cnt_t'(1);
                            lat_d[i] = cnt_t'(1);
                            if (!mon.ap_done[i]) begin
                                state_d[i] = BUSY;
                            end else if (mon.ap_continue[i]) begin
                                cmpl = 1'b1;
                            end else begin
                                state_d[i] = DONE_HOLD;
                            end
                        end
                    end
                    BUSY: begin
                        busy_d[i] = inc(busy_q[i]);
                        if (busy_q[i] == '1) ovf_d[i] = 1'b1;
                        rec      = inc(lat_q[i]);
                        lat_d[i] = rec;
                        if (lat_q[i] == '1) ovf_d[i] = 1'b1;
                        if (mon.ap_done[i]) begin
                            if (mon.ap_continue[i]) begin
                                cmpl       = 1'b1;
                                state_d[i] = IDLE;
                            end else begin
                                state_d[i] = DONE_HOLD;
                            end
                        end
                    end
                    DONE_HOLD: begin
                        stall_d[i] = inc(stall_q[i]);
                        if (stall_q[i] == '1) ovf_d[i] = 1'b1;
                        if (mon.ap_continue[i]) begin
                            cmpl       = 1'b1;
                            state_d[i] = IDLE;
                        end
                    end
                    default: state_d[i] = IDLE;
                endcase
                if (cmpl) begin
                    txn_d[i] = inc(txn_q[i]);
                    if (txn_q[i] == '1) ovf_d[i] = 1'b1;
                    last_d[i] = rec;
`ifdef MODULE_STATUS_MONITOR_MAXLAT_EN
                    if (rec > max_q[i]) max_d[i] = rec;
`endif
                end
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            frozen   <= 1'b0;
            overflow <= '0;
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                state_q[i] <= IDLE;
                lat_q[i]   <= '0;
                txn_q[i]   <= '0;
                last_q[i]  <= '0;
                busy_q[i]  <= '0;
                stall_q[i] <= '0;
                rdy_q[i]   <= '0;
`ifdef MODULE_STATUS_MONITOR_MAXLAT_EN
                max_q[i]   <= '0;
`endif
            end
        end else begin
            frozen   <= clear ? 1'b0 : frozen_d;
            overflow <= clear ? '0 : ovf_d;
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                state_q[i] <= clear ? IDLE : state_d[i];
                lat_q[i]   <= clear ? '0 : lat_d[i];
                txn_q[i]   <= clear ? '0 : txn_d[i];
                last_q[i]  <= clear ? '0 : last_d[i];
                busy_q[i]  <= clear ? '0 : busy_d[i];
                stall_q[i] <= clear ? '0 : stall_d[i];
                rdy_q[i]   <= clear ? '0 : rdy_d[i];
`ifdef MODULE_STATUS_MONITOR_MAXLAT_EN
                max_q[i]   <= clear ? '0 : max_d[i];
`endif
            end
        end
    end

    // Out-of-range channels match no index and fall through to zero.
    always_comb begin
        rd_val = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (mon.rd_ch == CH_W'(i)) begin
                case (mon.rd_sel)
                    3'd0:    rd_val = txn_q[i];
                    3'd1:    rd_val = last_q[i];
`ifdef MODULE_STATUS_MONITOR_MAXLAT_EN
                    3'd2:    rd_val = max_q[i];
`endif
                    3'd3:    rd_val = busy_q[i];
                    3'd4:    rd_val = stall_q[i];
                    3'd5:    rd_val = rdy_q[i];
                    3'd6:    rd_val = cnt_t'(state_q[i]);
                    default: rd_val = '0;
                endcase
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            mon.rd_valid <= 1'b0;
            mon.rd_data  <= '0;
        end else begin
            mon.rd_valid <= mon.rd_en;
            if (mon.rd_en) mon.rd_data <= rd_val;
        end
    end
endmodule

// File: doc/module_status_monitor.md
# module_status_monitor

Synthesizable, parametrised successor to the simulation-only per-module status monitors. It observes the ap_start/ap_ready/ap_done/ap_continue handshakes of up to NUM_CH HLS sub-modules and keeps per-channel performance counters in hardware. Counters are read back through a registered random-access read port. The block sits beside the HLS top level and is wired to the same handshake nets that the testbench monitors probe.

## Interface
- NUM_CH, 13: number of monitored channels (1..64); derived localparam CH_W = max(1, $clog2(NUM_CH)).
- CNT_W, 32: width of every counter and of rd_data (4..64).
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- ap_start  in  NUM_CH  per-channel start.
- ap_ready  in  NUM_CH  per-channel ready.
- ap_done  in  NUM_CH  per-channel done.
- ap_continue  in  NUM_CH  per-channel continue; tie high for channels without continue.
- finish  in  1  freeze request, sampled each cycle.
- clear  in  1  synchronous clear of all counters, FSMs, overflow and frozen.
- rd_en  in  1  read request.
- rd_ch  in  CH_W  channel to read.
- rd_sel  in  3  0 txn count, 1 last latency, 2 max latency, 3 busy cycles, 4 stall cycles, 5 ready count, 6 FSM state (zero-extended), 7 returns 0.
- rd_valid  out  1  one-cycle pulse, read data valid.
- rd_data  out  CNT_W  read data.
- frozen  out  1  sticky, counting stopped.
- overflow  out  NUM_CH  sticky per channel, some counter saturated.

## Operation
- Per-channel FSM: IDLE=0, BUSY=1, DONE_HOLD=2.
- IDLE: if ap_start=0, stay. If ap_start=1 and ap_done=0, go to BUSY and set lat_cnt=1. If ap_start=1 and ap_done=1, record latency 1; with ap_continue=1 the transaction completes and the FSM stays in IDLE; otherwise go to DONE_HOLD.
- BUSY: lat_cnt += 1 each cycle. On ap_done=1, record latency lat_cnt+1. Then: ap_continue=1 completes to IDLE; ap_continue=0 goes to DONE_HOLD.
- DONE_HOLD: stall += 1 each cycle. Leave when ap_continue=1: transaction completes and the FSM returns to IDLE. ap_done is not re-checked in this state.
- Completion: txn += 1; last latency is loaded with the recorded value; max latency updates if the recorded value is larger.
- busy counter: += 1 on every IDLE cycle with ap_start=1 and on every BUSY cycle.
- ready count: += 1 on every cycle with ap_ready=1, in any state.
- ap_start in any state other than IDLE is ignored.
- All counters saturate at 2^CNT_W-1. An increment attempted at saturation sets overflow[ch].
- finish=1 sampled: frozen=1 from the next cycle. Events in the finish cycle and all later cycles are not counted. FSMs and counters hold. Read port stays functional.
- clear=1: next cycle all counters, lat_cnt, overflow and frozen are 0 and all FSMs are IDLE. clear has priority over events and finish in the same cycle.
- Read: rd_ch >= NUM_CH returns 0 with rd_valid still pulsed. rd_en while frozen is allowed. A read returns the counter value as of the end of the rd_en cycle, excluding updates made in that same cycle.

## Timing
- Reset values: rd_valid=0, rd_data=0, frozen=0, overflow=0, all FSMs IDLE, all counters 0.
- Read latency is 1: rd_valid and rd_data are registered, both valid in cycle N+1 for rd_en in cycle N. A read may be issued every cycle.
- rd_data holds its last value when rd_en=0; rd_valid=0.
- Latency convention: ap_start sampled in IDLE in cycle t and ap_done in cycle t+k gives latency k+1.
- Reset asserted mid-transaction: immediate return to reset values. A done arriving after release in IDLE without ap_start is ignored.
- Channels with all inputs tied 0 stay IDLE with all counters 0.

## Configuration
- MODULE_STATUS_MONITOR_MAXLAT_EN defined: the per-channel max-latency register is built and rd_sel=2 returns it.
- Not defined: no max-latency registers are instantiated, rd_sel=2 returns 0, and max latency never sets overflow.

## Test plan
- Reset: hold reset low for 3 cycles with random inputs, release, read ch0 sel0..6 -> every rd_data=0, frozen=0, overflow=0.
- Basic transaction: ch3 ap_start cycle 0, ap_done+ap_continue cycle 4 -> txn=1, last=5, busy=5, stall=0, state=0.
- Stall: ch1 start cycle 0, done cycle 2 with continue=0, continue=1 in cycle 5 -> last=3, stall=3, txn=1; reading state during cycle 3 -> 2.
- Max latency: ch0 transactions of latency 5 then 2 -> last=2, max=5 with the macro; max=0 without it.
- Saturation with CNT_W=4: 17 single-cycle start+done+continue on ch2 -> txn=15, overflow=0b100 (bit 2 only); ch2 FSM stays IDLE throughout.
- Freeze/clear: finish during a BUSY transaction -> frozen=1 the next cycle; a later done+continue leaves txn unchanged; then clear -> all counters 0, frozen=0, FSMs IDLE.
